// File: rtl/cpu_fetch.sv
// Instruction fetch unit: walks a 4-bit PC, issues one memory request at a time
// and presents each fetched byte downstream with valid/ready handshaking.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | post-reset, no request; loads fetch address from PC
//   REQ   | request outstanding at imem_addr_o, waiting for ack
//   HOLD  | fetched instruction presented, waiting for downstream transfer
//   DRAIN | redirected mid-request; old request held until ack, data dropped
module cpu_fetch (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       redirect_i,
  input  logic [3:0] redirect_pc_i,
  output logic       imem_req_o,
  output logic [3:0] imem_addr_o,
  input  logic       imem_ack_i,
  input  logic [7:0] imem_data_i,
  output logic       inst_valid_o,
  output logic [7:0] inst_o,
  output logic [3:0] inst_pc_o,
  input  logic       inst_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] inst_q, inst_d;
  logic [3:0] inst_pc_q, inst_pc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= 4'd0;
      addr_q    <= 4'd0;
      inst_q    <= 8'd0;
      inst_pc_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_i) begin
          pc_d   = redirect_pc_i;
          addr_d = redirect_pc_i;
        end else begin
          addr_d = pc_q;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (imem_ack_i) addr_d  = redirect_pc_i;
          else            state_d = S_DRAIN;
        end else if (imem_ack_i) begin
          inst_d    = imem_data_i;
          inst_pc_d = addr_q;
          pc_d      = addr_q + 4'd1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          addr_d  = redirect_pc_i;
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_i) pc_d = redirect_pc_i;
        // An ack retires the stale request; a same-cycle redirect target wins.
        if (imem_ack_i) begin
          addr_d  = redirect_i ? redirect_pc_i : pc_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_o   = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (state_q == S_HOLD);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: memory returns 0xA0+addr; a program-order model checks
// every presented instruction, plus directed literal checks for each scenario.
module tb_cpu_fetch;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       redirect_i = 1'b0;
  logic [3:0] redirect_pc_i = 4'd0;
  logic       imem_req_o;
  logic [3:0] imem_addr_o;
  logic       imem_ack_i;
  logic [7:0] imem_data_i;
  logic       inst_valid_o;
  logic [7:0] inst_o;
  logic [3:0] inst_pc_o;
  logic       inst_ready_i = 1'b0;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  logic run      = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_ack_i  = auto_ack ? imem_req_o : man_ack;
  assign imem_data_i = 8'hA0 + {4'd0, imem_addr_o};

  cpu_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: the next instruction shown must be the one after the
  // last transfer, or the most recent redirect target.
  logic [3:0] exp_pc = 4'd0;
  logic       prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [3:0] prev_addr = 4'd0;

  always @(posedge clk) begin
    if (rst_i)                           exp_pc <= 4'd0;
    else if (redirect_i)                 exp_pc <= redirect_pc_i;
    else if (inst_valid_o && inst_ready_i) exp_pc <= inst_pc_o + 4'd1;
    prev_req  <= imem_req_o;
    prev_ack  <= imem_ack_i;
    prev_addr <= imem_addr_o;
    prev_rst  <= rst_i;
  end

  always @(negedge clk) begin
    if (run) begin
      chk("req_valid_exclusive", {31'd0, imem_req_o && inst_valid_o}, 32'd0);
      if (inst_valid_o) begin
        chk("model_inst_pc", {28'd0, inst_pc_o}, {28'd0, exp_pc});
        chk("model_inst", {24'd0, inst_o}, {24'd0, 8'hA0 + {4'd0, inst_pc_o}});
      end
      if (prev_req && !prev_ack && !prev_rst) begin
        chk("req_held", {31'd0, imem_req_o}, 32'd1);
        chk("req_addr_stable", {28'd0, imem_addr_o}, {28'd0, prev_addr});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [3:0] a);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < 40) begin
      step();
      n++;
    end
    chk("wait_req", {31'd0, imem_req_o && imem_addr_o == a}, 32'd1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_req"},   {31'd0, imem_req_o},   32'd0);
    chk({name, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({name, "_addr"},  {28'd0, imem_addr_o},  32'd0);
    chk({name, "_inst"},  {24'd0, inst_o},       32'd0);
    chk({name, "_pc"},    {28'd0, inst_pc_o},    32'd0);
  endtask

  initial begin
    // Reset and first request timing
    step();
    step();
    run = 1'b1;
    chk_zero("reset");
    rst_i = 1'b0;
    chk_zero("idle");
    step();
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", {28'd0, imem_addr_o}, 32'd0);

    // Streaming with zero-wait ack and ready high: one per 2 cycles, wraps
    auto_ack = 1'b1;
    inst_ready_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      if (k > 0) step();
      chk("stream_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stream_pc", {28'd0, inst_pc_o}, k % 16);
      chk("stream_inst", {24'd0, inst_o}, 32'hA0 + (k % 16));
    end

    // Downstream stall while holding pc 3
    wait_req(4'd3);
    inst_ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stall_inst", {24'd0, inst_o}, 32'hA3);
      chk("stall_pc", {28'd0, inst_pc_o}, 32'd3);
      chk("stall_req", {31'd0, imem_req_o}, 32'd0);
      step();
    end
    inst_ready_i = 1'b1;
    step();
    chk("after_stall_req", {31'd0, imem_req_o}, 32'd1);
    chk("after_stall_addr", {28'd0, imem_addr_o}, 32'd4);

    // Redirect while a request is outstanding with ack withheld
    wait_req(4'd5);
    auto_ack = 1'b0;
    step();
    chk("wait5_addr", {28'd0, imem_addr_o}, 32'd5);
    redirect_i = 1'b1;
    redirect_pc_i = 4'hC;
    step();
    redirect_i = 1'b0;
    chk("drain_req", {31'd0, imem_req_o}, 32'd1);
    chk("drain_addr", {28'd0, imem_addr_o}, 32'd5);
    step();
    chk("drain_addr2", {28'd0, imem_addr_o}, 32'd5);
    man_ack = 1'b1;
    step();
    chk("drain_dropped", {31'd0, inst_valid_o}, 32'd0);
    chk("redir_req", {31'd0, imem_req_o}, 32'd1);
    chk("redir_addr", {28'd0, imem_addr_o}, 32'hC);
    step();
    man_ack = 1'b0;
    auto_ack = 1'b1;
    chk("redir_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("redir_pc", {28'd0, inst_pc_o}, 32'hC);
    chk("redir_inst", {24'd0, inst_o}, 32'hAC);

    // Redirect in the same cycle as the ack for addr 2
    wait_req(4'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 4'd9;
    step();
    redirect_i = 1'b0;
    chk("ackredir_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("ackredir_addr", {28'd0, imem_addr_o}, 32'd9);
    step();
    chk("ackredir_pc", {28'd0, inst_pc_o}, 32'd9);
    chk("ackredir_inst", {24'd0, inst_o}, 32'hA9);

    // Redirect in HOLD without transfer drops the held instruction
    inst_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 4'hE;
    step();
    redirect_i = 1'b0;
    inst_ready_i = 1'b1;
    chk("holdredir_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("holdredir_addr", {28'd0, imem_addr_o}, 32'hE);
    step();
    chk("holdredir_pc", {28'd0, inst_pc_o}, 32'hE);

    // Reset during DRAIN with ack asserted
    step();
    auto_ack = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 4'd7;
    step();
    redirect_i = 1'b0;
    chk("pre_rst_drain_req", {31'd0, imem_req_o}, 32'd1);
    chk("pre_rst_drain_addr", {28'd0, imem_addr_o}, 32'hF);
    rst_i = 1'b1;
    man_ack = 1'b1;
    step();
    chk_zero("rst_drain");
    rst_i = 1'b0;
    man_ack = 1'b0;
    step();
    chk("rst2_req", {31'd0, imem_req_o}, 32'd1);
    chk("rst2_addr", {28'd0, imem_addr_o}, 32'd0);
    auto_ack = 1'b1;
    step();
    chk("rst2_pc", {28'd0, inst_pc_o}, 32'd0);
    chk("rst2_inst", {24'd0, inst_o}, 32'hA0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 clk_i  input  1  clock; all state SHALL update on the rising edge only.
REQ-002 rst_i  input  1  reset; SHALL be synchronous and active-high.
REQ-003 redirect_i  input  1  load a new PC; flushes in-flight work.
REQ-004 redirect_pc_i  input  4  target PC, sampled when redirect_i=1.
REQ-005 imem_req_o  output  1  instruction memory request.
REQ-006 imem_addr_o  output  4  memory address; registered.
REQ-007 imem_ack_i  input  1  memory response; imem_data_i valid in the same cycle.
REQ-008 imem_data_i  input  8  instruction byte.
REQ-009 inst_valid_o  output  1  inst_o and inst_pc_o hold a fetched instruction.
REQ-010 inst_o  output  8  fetched instruction.
REQ-011 inst_pc_o  output  4  PC of inst_o.
REQ-012 inst_ready_i  input  1  downstream accepts; a transfer occurs on a cycle with inst_valid_o=1 and inst_ready_i=1.

Function
REQ-013 The block SHALL hold a 4-bit PC register. Increment SHALL be modulo 16, so 15 -> 0 with no flag.
REQ-014 The FSM SHALL have the states IDLE, REQ, HOLD and DRAIN.
REQ-015 IDLE: all outputs SHALL be low. The FSM SHALL go to REQ in the next cycle, with imem_addr_o loaded from the PC.
REQ-016 REQ: imem_req_o=1 and imem_addr_o stable. On imem_ack_i=1 the block SHALL do all of the following at that edge: inst_o<=imem_data_i, inst_pc_o<=imem_addr_o, PC<=imem_addr_o+1, go to HOLD.
REQ-017 HOLD: inst_valid_o=1 and imem_req_o=0. inst_o and inst_pc_o SHALL stay stable until transfer.
REQ-018 HOLD: on transfer, the FSM SHALL go to REQ with imem_addr_o<=PC.
REQ-019 Once asserted, imem_req_o SHALL stay high with imem_addr_o unchanged until imem_ack_i=1. A request is never withdrawn.
REQ-020 Redirect in IDLE or HOLD: PC<=redirect_pc_i, imem_addr_o<=redirect_pc_i, inst_valid_o<=0, go to REQ.
REQ-021 Redirect in HOLD together with inst_ready_i: the transfer still counts on that cycle, and the redirect is applied as in REQ-020.
REQ-022 Redirect in REQ with imem_ack_i=1: imem_data_i SHALL be discarded (inst_valid_o stays 0), PC<=redirect_pc_i, imem_addr_o<=redirect_pc_i, stay in REQ.
REQ-023 Redirect in REQ with imem_ack_i=0: PC<=redirect_pc_i, go to DRAIN. imem_addr_o SHALL keep the old address.
REQ-024 DRAIN: imem_req_o=1 with the old address. On imem_ack_i the data SHALL be discarded, imem_addr_o<=PC, go to REQ.
REQ-025 Redirect in DRAIN: PC<=redirect_pc_i, stay in DRAIN. The last redirect wins.
REQ-026 inst_valid_o SHALL be high only in HOLD. imem_req_o SHALL be high only in REQ or DRAIN.
REQ-027 Best-case throughput SHALL be one instruction per 2 cycles, given zero-wait ack and ready held high.

Reset
REQ-028 rst_i=1 SHALL override all other inputs on that edge. Resulting values: state=IDLE, PC=0, imem_addr_o=0, imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-029 Reset mid-transaction (REQ, DRAIN or HOLD) SHALL abandon that transaction without completing it. Any ack in the reset cycle SHALL be ignored.
REQ-030 The first request after reset release SHALL assert 2 cycles after rst_i falls (IDLE, then REQ) with imem_addr_o=0.

Verification
REQ-031 Reset, then ack every request with data=0xA0+addr and inst_ready_i=1. Required: inst_o/inst_pc_o = A0/0, A1/1, … AF/F, A0/0, one every 2 cycles.
REQ-032 Set inst_ready_i=0 for 5 cycles while in HOLD with inst_pc_o=3. Required: inst_valid_o, inst_o and inst_pc_o stay constant, imem_req_o=0, and the next fetch uses addr 4.
REQ-033 While REQ addr=5 with ack withheld, assert redirect_i with redirect_pc_i=C. Required: imem_addr_o stays 5 until ack, that data is dropped, and the next request uses addr C; inst_pc_o=C is the first valid.
REQ-034 Redirect to 9 in the same cycle as ack for addr 2. Required: no instruction with pc 2 appears, and the next request uses addr 9.
REQ-035 Assert rst_i during DRAIN with ack asserted. Required: all outputs 0 on the next cycle, and the first request after release uses addr 0.
